// File: rtl/rs_strobe_arbiter_if.sv
// Requester-side and latch-bank-side signals of the strobe arbiter, bundled for one port.
// The master modport is the requester/bank side; the slave modport is the arbiter.
interface rs_strobe_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IW   = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      s_req;
  logic [NREQ-1:0]      r_req;
  logic [NREQ*IW-1:0]   idx_req;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      nak;
  logic                 s;
  logic                 r;
  logic [IW-1:0]        sel;
  logic                 en;
  logic                 busy;
  logic [(1<<IW)-1:0]   q_shadow;

  modport master (
    output req, s_req, r_req, idx_req,
    input  ack, nak, s, r, sel, en, busy, q_shadow
  );

  modport slave (
    input  req, s_req, r_req, idx_req,
    output ack, nak, s, r, sel, en, busy, q_shadow
  );
endinterface

// File: rtl/rs_strobe_arbiter.sv
// Round-robin sequencer sharing one S/R latch bank: grant -> setup -> strobe -> hold -> ack, 5 cycles/command.
// Requesters hold req until a one-cycle ack/nak; s=r=1 is rejected in 2 cycles without touching the bank.
module rs_strobe_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  rs_strobe_arbiter_if.slave  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LN = 1 << IW;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, REJ} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   win_q;
  logic            s_q;
  logic            r_q;
  logic            en_q;
  logic            busy_q;
  logic [IW-1:0]   sel_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] nak_q;
  logic [LN-1:0]   shadow_q;

  logic            any_d;
  logic [PW-1:0]   win_d;
  logic [PW-1:0]   cand;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
    logic [PW:0] sum;
    sum = {1'b0, a} + (PW+1)'(k);
    if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
    return sum[PW-1:0];
  endfunction

  // First requesting index at or after the pointer wins.
  always_comb begin
    any_d = 1'b0;
    win_d = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!any_d && bus.req[cand]) begin
        any_d = 1'b1;
        win_d = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      sel_q    <= '0;
      ack_q    <= '0;
      nak_q    <= '0;
      shadow_q <= '0;
    end else begin
      ack_q <= '0;
      nak_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_d) begin
            win_q  <= win_d;
            busy_q <= 1'b1;
            if (bus.s_req[win_d] && bus.r_req[win_d]) begin
              nak_q   <= NREQ'(1) << win_d;
              state_q <= REJ;
            end else begin
              s_q     <= bus.s_req[win_d];
              r_q     <= bus.r_req[win_d];
              sel_q   <= bus.idx_req[int'(win_d)*IW +: IW];
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          en_q    <= 1'b1;
          state_q <= STROBE;
        end
        STROBE: begin
          en_q    <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: begin
          s_q   <= 1'b0;
          r_q   <= 1'b0;
          ack_q <= NREQ'(1) << win_q;
          if (s_q)      shadow_q[sel_q] <= 1'b1;
          else if (r_q) shadow_q[sel_q] <= 1'b0;
          state_q <= DONE;
        end
        DONE, REJ: begin
          busy_q  <= 1'b0;
          ptr_q   <= wrap_add(win_q, 1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.en       = en_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.nak      = nak_q;
  assign bus.q_shadow = shadow_q;
endmodule

// File: tb/tb_rs_strobe_arbiter.sv
// Directed bench for rs_strobe_arbiter: set/clear, reject, round-robin order, in-flight input changes, mid-sequence reset.
module tb_rs_strobe_arbiter;
  localparam int NREQ = 4;
  localparam int IW   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   en_cnt;
  int   busy_cnt;

  always #5 clk = ~clk;

  rs_strobe_arbiter_if #(.NREQ(NREQ), .IW(IW)) bus ();

  rs_strobe_arbiter #(.NREQ(NREQ), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int i, input int v);
    bus.idx_req[i*IW +: IW] = 3'(v);
  endtask

  // Entered in the IDLE cycle whose closing edge grants w; returns in the following IDLE cycle.
  task automatic strobe_seq(input string tag, input int w, input int es, input int er,
                            input int ei, input int eq, input bit mutate);
    tick;
    chk({tag, ".setup_s"},    32'(bus.s),    es);
    chk({tag, ".setup_r"},    32'(bus.r),    er);
    chk({tag, ".setup_sel"},  32'(bus.sel),  ei);
    chk({tag, ".setup_en"},   32'(bus.en),   0);
    chk({tag, ".setup_busy"}, 32'(bus.busy), 1);
    if (mutate) begin
      bus.req[w]   = 1'b0;
      bus.s_req[w] = ~bus.s_req[w];
      set_idx(w, ei ^ 7);
    end
    tick;
    chk({tag, ".strobe_en"},  32'(bus.en),   1);
    chk({tag, ".strobe_s"},   32'(bus.s),    es);
    chk({tag, ".strobe_sel"}, 32'(bus.sel),  ei);
    chk({tag, ".strobe_ack"}, 32'(bus.ack),  0);
    tick;
    chk({tag, ".hold_en"},    32'(bus.en),   0);
    chk({tag, ".hold_s"},     32'(bus.s),    es);
    chk({tag, ".hold_r"},     32'(bus.r),    er);
    chk({tag, ".hold_sel"},   32'(bus.sel),  ei);
    tick;
    chk({tag, ".done_ack"},   32'(bus.ack),  1 << w);
    chk({tag, ".done_nak"},   32'(bus.nak),  0);
    chk({tag, ".done_en"},    32'(bus.en),   0);
    chk({tag, ".done_s"},     32'(bus.s),    0);
    chk({tag, ".done_q"},     32'(bus.q_shadow), eq);
    chk({tag, ".done_busy"},  32'(bus.busy), 1);
    tick;
    chk({tag, ".idle_ack"},   32'(bus.ack),  0);
    chk({tag, ".idle_busy"},  32'(bus.busy), 0);
    chk({tag, ".idle_sel"},   32'(bus.sel),  ei);
  endtask

  initial begin
    bus.req     = '0;
    bus.s_req   = '0;
    bus.r_req   = '0;
    bus.idx_req = '0;

    #2 rst_n = 1'b0;
    tick;
    tick;
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.en",   32'(bus.en),   0);
    chk("rst.s",    32'(bus.s),    0);
    chk("rst.r",    32'(bus.r),    0);
    chk("rst.sel",  32'(bus.sel),  0);
    chk("rst.ack",  32'(bus.ack),  0);
    chk("rst.nak",  32'(bus.nak),  0);
    chk("rst.q",    32'(bus.q_shadow), 0);
    rst_n = 1'b1;

    en_cnt   = 0;
    busy_cnt = 0;
    repeat (20) begin
      tick;
      if (bus.en !== 1'b0)   en_cnt++;
      if (bus.busy !== 1'b0) busy_cnt++;
    end
    chk("idle.en_pulses",  32'(en_cnt),   0);
    chk("idle.busy_count", 32'(busy_cnt), 0);
    chk("idle.ack",        32'(bus.ack),  0);

    // Set latch 5 from requester 1, then clear it again.
    bus.s_req = 4'b0010;
    set_idx(1, 5);
    bus.req = 4'b0010;
    strobe_seq("set5", 1, 1, 0, 5, 'h20, 1'b0);
    bus.req   = '0;
    bus.s_req = '0;
    bus.r_req = 4'b0010;
    bus.req   = 4'b0010;
    strobe_seq("clr5", 1, 0, 1, 5, 'h00, 1'b0);
    bus.req   = '0;
    bus.r_req = '0;

    // Forbidden command from requester 2 while requester 3 also waits.
    bus.s_req = 4'b1100;
    bus.r_req = 4'b0100;
    set_idx(2, 4);
    set_idx(3, 2);
    bus.req = 4'b1100;
    tick;
    chk("rej.nak",  32'(bus.nak),  4);
    chk("rej.ack",  32'(bus.ack),  0);
    chk("rej.en",   32'(bus.en),   0);
    chk("rej.s",    32'(bus.s),    0);
    chk("rej.r",    32'(bus.r),    0);
    chk("rej.busy", 32'(bus.busy), 1);
    chk("rej.sel",  32'(bus.sel),  5);
    chk("rej.q",    32'(bus.q_shadow), 0);
    tick;
    chk("rej_idle.nak",  32'(bus.nak),  0);
    chk("rej_idle.busy", 32'(bus.busy), 0);
    chk("rej_idle.en",   32'(bus.en),   0);
    strobe_seq("after_rej", 3, 1, 0, 2, 'h04, 1'b0);
    bus.req   = '0;
    bus.r_req = '0;

    // All four requesting: served 0,1,2,3,0.
    bus.s_req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_idx(i, i);
    bus.req = 4'b1111;
    strobe_seq("rr_a0", 0, 1, 0, 0, 'h05, 1'b0);
    strobe_seq("rr_a1", 1, 1, 0, 1, 'h07, 1'b0);
    strobe_seq("rr_a2", 2, 1, 0, 2, 'h07, 1'b0);
    strobe_seq("rr_a3", 3, 1, 0, 3, 'h0F, 1'b0);
    strobe_seq("rr_a0b", 0, 1, 0, 0, 'h0F, 1'b0);
    set_idx(3, 5);
    set_idx(0, 6);
    bus.req = 4'b1001;
    strobe_seq("rr_b3", 3, 1, 0, 5, 'h2F, 1'b0);
    strobe_seq("rr_b0", 0, 1, 0, 6, 'h6F, 1'b0);
    bus.req = '0;

    // Winner changes its inputs and drops req right after grant.
    bus.s_req = 4'b0010;
    set_idx(1, 7);
    bus.req = 4'b0010;
    strobe_seq("inflight", 1, 1, 0, 7, 'hEF, 1'b1);
    bus.req = '0;

    // Reset while the strobe is high.
    bus.s_req = 4'b0100;
    set_idx(2, 3);
    bus.req = 4'b0100;
    tick;
    chk("midrst.setup_busy", 32'(bus.busy), 1);
    tick;
    chk("midrst.strobe_en", 32'(bus.en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.en",   32'(bus.en),   0);
    chk("midrst.busy", 32'(bus.busy), 0);
    chk("midrst.q",    32'(bus.q_shadow), 0);
    chk("midrst.s",    32'(bus.s),    0);
    chk("midrst.sel",  32'(bus.sel),  0);
    bus.req = '0;
    tick;
    tick;
    chk("midrst.ack", 32'(bus.ack), 0);
    chk("midrst.nak", 32'(bus.nak), 0);
    rst_n = 1'b1;

    // Pointer back at 0: requester 1 beats requester 2.
    bus.s_req = 4'b0110;
    set_idx(1, 0);
    set_idx(2, 3);
    bus.req = 4'b0110;
    strobe_seq("post_rst", 1, 1, 0, 0, 'h01, 1'b0);
    bus.req = '0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_strobe_arbiter.md
# rs_strobe_arbiter

Round-robin scheduler that shares one set/reset latch bank among NREQ requesters. It accepts set/reset/hold commands and sequences the bank's s/r/sel inputs and positive-edge enable strobe with guaranteed setup and hold cycles. It rejects the forbidden s=r=1 combination and keeps a shadow copy of the expected latch state. It sits between requester logic and the latch bank.

## Interface
- NREQ, 4: number of requesters (2..8)
- IW, 3: latch index width; bank holds 2**IW latches
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held until ack/nak
- s_req  in  NREQ  per-requester set bit
- r_req  in  NREQ  per-requester reset bit
- idx_req  in  NREQ*IW  per-requester latch index; requester i uses bits [i*IW +: IW]
- ack  out  NREQ  one-cycle pulse: command i completed
- nak  out  NREQ  one-cycle pulse: command i rejected (s=r=1)
- s  out  1  set input to latch bank
- r  out  1  reset input to latch bank
- sel  out  IW  latch select to bank
- en  out  1  enable strobe to bank (bank acts on rising edge)
- busy  out  1  high in every state except IDLE
- q_shadow  out  2**IW  expected q of each latch

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE, REJ.
- IDLE: if any req is high, grant winner w, searching ptr, ptr+1, … mod NREQ.
  - Capture s_req[w], r_req[w] and idx_req[w] into command registers.
  - If s=r=1, go to REJ. Otherwise go to SETUP.
  - No req high: stay in IDLE.
- SETUP: drive s, r, sel from the captured command; en=0.
- STROBE: en=1; s, r, sel unchanged.
- HOLD: en=0; s, r, sel unchanged.
- DONE: ack[w]=1; update q_shadow[sel]:
  - s=1: set to 1.
  - r=1: clear to 0.
  - s=r=0: unchanged. This is a hold command; it still strobes.
  - ptr ← (w+1) mod NREQ. Go to IDLE.
- REJ: nak[w]=1; s, r, en stay 0; q_shadow unchanged; ptr ← (w+1) mod NREQ. Go to IDLE.
- In IDLE, DONE and REJ: s=0, r=0, en=0; sel keeps its last value.
- Commands are captured at grant. Later changes to s_req, r_req, idx_req or req[w] do not affect the command in flight.
- req is level-sensitive. If req[w] is still high in the IDLE cycle after ack/nak, it is arbitrated again as a new command.
- A requester's deasserting req before ack does not abort a granted command; ack still pulses.
- At most one ack/nak bit is high in any cycle; ack and nak are never high together.
- No arithmetic beyond ptr increment modulo NREQ, which wraps NREQ-1 → 0.

## Timing
- Reset, asynchronous on rst_n low, takes effect immediately:
  - State IDLE; ptr=0.
  - s=0, r=0, en=0, sel=0.
  - ack=0, nak=0, busy=0, q_shadow=0 (all bits).
- Reset mid-sequence: en drops the same instant. No ack/nak is issued and q_shadow is cleared.
- Grant in cycle t (IDLE, req sampled high):
  - SETUP t+1, STROBE t+2 (en high exactly one cycle), HOLD t+3, DONE t+4 (ack high).
  - IDLE t+5; the earliest next grant is sampled at t+5.
- Reject: grant at t, REJ at t+1 (nak high), IDLE at t+2.
- s/r/sel are stable one full cycle before en rises and one full cycle after en falls.
- busy is high for cycles t+1..t+4 (strobe) or t+1 (reject).
- Service throughput: one command per 5 cycles.
- Fairness: with all requesters continuously requesting, each is served once every NREQ commands.

## Test plan
- Reset/idle: hold rst_n=0, then release with req=0 → all outputs 0, busy=0, en never pulses over 20 cycles.
- Single set: req[1]=1, s_req[1]=1, idx=5 at cycle t →
  - s=1, sel=5 at t+1..t+3; en=1 only at t+2; ack[1]=1 at t+4.
  - q_shadow=8'h20. Follow with a reset of idx 5 → q_shadow=0.
- Forbidden input: req[2], s_req[2]=r_req[2]=1 → nak[2]=1 at t+1, en stays 0, q_shadow unchanged; the next grant goes to requester 3.
- Round-robin: req=4'b1111, all set, idx=i → ack order 0,1,2,3,0. Then req=4'b1001 with ptr=1 → requester 3 is served before 0.
- Input change in flight: after grant, flip s_req/idx_req of the winner and drop its req → the captured command still strobes and ack still pulses.
- Reset mid-sequence: assert rst_n=0 during STROBE → en falls immediately, no ack, q_shadow=0, ptr=0 after release.
